// File: rtl/match_report_tx_pkg.sv
// Shared definitions for the match report transmitter: word tags, FSM states,
// the per-packet descriptor layout and helpers that build output words.
package match_report_tx_pkg;

  localparam logic [1:0] HDR_TAG  = 2'b10;
  localparam logic [1:0] BODY_TAG = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // One descriptor per packet that stored at least one ID.
  typedef struct packed {
    logic       ovf;
    logic [7:0] count;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  function automatic logic [15:0] make_header(input desc_t d);
    return {HDR_TAG, d.ovf, 5'b0, d.count};
  endfunction

  function automatic logic [15:0] make_body(input logic [13:0] id);
    return {BODY_TAG, id};
  endfunction

endpackage

// File: rtl/match_report_tx_if.sv
// Report output stream: valid/ready with a last-word marker.
//   out_data  : header or body word
//   out_valid : out_data valid
//   out_ready : consumer accepts on out_valid & out_ready
//   out_last  : final word of a report
interface match_report_tx_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/match_report_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   push/din   : write when not full, or when a same-cycle pop frees a slot
//   pop/dout   : dout shows the head; pop advances it when not empty
//   full/empty : from the registered occupancy
module match_report_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage carries no reset; only pointers and occupancy define contents,
  // so flushing them is enough and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/match_report_tx.sv
// Buffers non-zero pattern IDs per packet and sends one framed report per
// packet: a header {10,ovf,00000,count} followed by one body word per ID.
//   clk, reset  : single clock, async active-high reset
//   pattern_in  : matched ID, 0 = no match (no backpressure possible)
//   pattern_eop : last cycle of the current packet
//   tx          : report stream (master side)
//   drop_cnt    : saturating count of dropped IDs
//   busy        : report queued or in flight
module match_report_tx
  import match_report_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PER_PKT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [13:0]          pattern_in,
  input  logic                 pattern_eop,
  match_report_tx_if.master    tx,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_PER_PKT);

  logic        id_push, id_pop, id_full, id_empty;
  logic [13:0] id_dout;
  logic        desc_push, desc_pop, desc_full, desc_empty;
  desc_t       desc_din, desc_dout;

  logic        hit, drop, hs;
  logic [7:0]  pkt_cnt, cnt_now, remaining;
  logic        pkt_ovf;
  state_t      state;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit            = (pattern_in != '0);
    id_push        = hit && (!id_full || id_pop) && (pkt_cnt < MAX_CNT);
    drop           = hit && !id_push;
    cnt_now        = pkt_cnt + 8'(id_push);
    desc_din.ovf   = pkt_ovf | drop;
    desc_din.count = cnt_now;
    // A packet that stored nothing produces no report, even if it overflowed.
    desc_push      = pattern_eop && (cnt_now != '0) && !desc_full;
  end

  always_comb begin
    hs       = tx.out_valid && tx.out_ready;
    id_pop   = 1'b0;
    desc_pop = 1'b0;
    unique case (state)
      ST_IDLE: desc_pop = !desc_empty;
      ST_HDR:  id_pop   = hs && !id_empty;
      ST_BODY: begin
        if (hs && tx.out_last) desc_pop = !desc_empty;
        else if (hs)           id_pop   = !id_empty;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE) || !desc_empty;

  match_report_tx_sync_fifo #(.WIDTH(14), .DEPTH(FIFO_DEPTH)) u_id_fifo (
    .clk(clk), .reset(reset), .push(id_push), .din(pattern_in), .pop(id_pop),
    .dout(id_dout), .full(id_full), .empty(id_empty)
  );

  match_report_tx_sync_fifo #(.WIDTH(DESC_W), .DEPTH(FIFO_DEPTH)) u_desc_fifo (
    .clk(clk), .reset(reset), .push(desc_push), .din(desc_din), .pop(desc_pop),
    .dout(desc_dout), .full(desc_full), .empty(desc_empty)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt  <= '0;
      pkt_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pattern_eop) begin
        pkt_cnt <= '0;
        pkt_ovf <= 1'b0;
      end else begin
        pkt_cnt <= cnt_now;
        pkt_ovf <= pkt_ovf | drop;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // The output register holds the word currently offered; an ID is popped
  // from its FIFO at the moment it is loaded, so `remaining` counts IDs not
  // yet loaded and out_last is set when the final one goes in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      tx.out_valid <= 1'b0;
      tx.out_data  <= '0;
      tx.out_last  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!desc_empty) begin
            state        <= ST_HDR;
            remaining    <= desc_dout.count;
            tx.out_valid <= 1'b1;
            tx.out_data  <= make_header(desc_dout);
            tx.out_last  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (hs) begin
            state       <= ST_BODY;
            remaining   <= remaining - 8'd1;
            tx.out_data <= make_body(id_dout);
            tx.out_last <= (remaining == 8'd1);
          end
        end
        ST_BODY: begin
          if (hs) begin
            if (tx.out_last) begin
              if (!desc_empty) begin
                // Back-to-back report: next header with no idle cycle.
                state       <= ST_HDR;
                remaining   <= desc_dout.count;
                tx.out_data <= make_header(desc_dout);
                tx.out_last <= 1'b0;
              end else begin
                state        <= ST_IDLE;
                tx.out_valid <= 1'b0;
                tx.out_last  <= 1'b0;
              end
            end else begin
              remaining   <= remaining - 8'd1;
              tx.out_data <= make_body(id_dout);
              tx.out_last <= (remaining == 8'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_report_tx.sv
module tb_match_report_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] pattern_in;
  logic        pattern_eop;
  logic [15:0] drop_cnt;
  logic        busy;

  match_report_tx_if tx_if ();

  match_report_tx dut (
    .clk(clk), .reset(reset), .pattern_in(pattern_in), .pattern_eop(pattern_eop),
    .tx(tx_if), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ready_pct = 100;
  bit stalled = 1'b0;
  logic [15:0] hold_d;
  logic        hold_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send(input logic [13:0] id, input logic eop);
    pattern_in  = id;
    pattern_eop = eop;
    @(negedge clk);
    pattern_in  = '0;
    pattern_eop = 1'b0;
  endtask

  // Waits (bounded) for the next accepted word and compares it; while the
  // consumer stalls, the offered word must stay put.
  task automatic pop_word(input logic [15:0] exp_d, input logic exp_l,
                          input string tag, input int max_wait);
    int waited = 0;
    bit done = 1'b0;
    while (!done) begin
      if (stalled) begin
        check({tag, " hold_valid"}, 32'(tx_if.out_valid), 32'd1);
        check({tag, " hold_data"},  32'(tx_if.out_data),  32'(hold_d));
        check({tag, " hold_last"},  32'(tx_if.out_last),  32'(hold_l));
      end
      tx_if.out_ready = ($urandom_range(0, 99) < ready_pct);
      if (tx_if.out_valid && tx_if.out_ready) begin
        check({tag, " data"}, 32'(tx_if.out_data), 32'(exp_d));
        check({tag, " last"}, 32'(tx_if.out_last), 32'(exp_l));
        stalled = 1'b0;
        done    = 1'b1;
      end else begin
        stalled = tx_if.out_valid;
        hold_d  = tx_if.out_data;
        hold_l  = tx_if.out_last;
        if (!tx_if.out_valid && waited >= max_wait) begin
          vectors++;
          miscompares++;
          $error("FAIL %s: no word after %0d cycles, required %0h", tag, waited, exp_d);
          done = 1'b1;
        end
        waited++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [13:0] ids [4];
    int k;

    reset = 1'b1;
    pattern_in = '0;
    pattern_eop = 1'b0;
    tx_if.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(tx_if.out_valid), 32'd0);
    check("rst out_last",  32'(tx_if.out_last),  32'd0);
    check("rst out_data",  32'(tx_if.out_data),  32'd0);
    check("rst drop_cnt",  32'(drop_cnt),        32'd0);
    check("rst busy",      32'(busy),            32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: two IDs, header two cycles after eop
    send(14'h0012, 1'b0);
    send(14'h0345, 1'b1);
    check("t1 valid at eop+1", 32'(tx_if.out_valid), 32'd0);
    check("t1 busy at eop+1",  32'(busy),            32'd1);
    ready_pct = 100;
    pop_word(16'h8002, 1'b0, "t1 hdr", 1);
    pop_word(16'h0012, 1'b0, "t1 id0", 0);
    pop_word(16'h0345, 1'b1, "t1 id1", 0);
    check("t1 idle valid", 32'(tx_if.out_valid), 32'd0);
    check("t1 idle busy",  32'(busy),            32'd0);

    // 2: empty packet produces nothing
    tx_if.out_ready = 1'b0;
    send(14'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2 valid", 32'(tx_if.out_valid), 32'd0);
      check("t2 busy",  32'(busy),            32'd0);
      @(negedge clk);
    end
    check("t2 drop_cnt", 32'(drop_cnt), 32'd0);

    // 3: 17 IDs, only 15 stored, consumer stalled during ingest
    tx_if.out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) send(14'(i), (i == 17));
    @(negedge clk);
    @(negedge clk);
    check("t3 drop_cnt",   32'(drop_cnt),        32'd2);
    check("t3 stall valid", 32'(tx_if.out_valid), 32'd1);
    check("t3 stall hdr",  32'(tx_if.out_data),  32'hA00F);
    check("t3 busy",       32'(busy),            32'd1);
    ready_pct = 100;
    pop_word(16'hA00F, 1'b0, "t3 hdr", 0);
    for (int i = 1; i <= 15; i++) pop_word(16'(i), (i == 15), "t3 body", 0);
    check("t3 idle valid", 32'(tx_if.out_valid), 32'd0);

    // 4: back-to-back single-ID reports
    tx_if.out_ready = 1'b0;
    send(14'h0007, 1'b1);
    send(14'h0009, 1'b1);
    ready_pct = 100;
    pop_word(16'h8001, 1'b0, "t4 hdr0", 1);
    pop_word(16'h0007, 1'b1, "t4 id0",  0);
    pop_word(16'h8001, 1'b0, "t4 hdr1", 0);
    pop_word(16'h0009, 1'b1, "t4 id1",  0);
    check("t4 idle valid", 32'(tx_if.out_valid), 32'd0);

    // 5: 200 random packets with random consumer stalls
    ready_pct = 50;
    for (int p = 0; p < 200; p++) begin
      tx_if.out_ready = 1'b0;
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) ids[j] = 14'($urandom_range(1, 16383));
      if (k == 0) send(14'h0000, 1'b1);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) send(14'h0000, 1'b0);
        send(ids[j], (j == k - 1));
      end
      if (k > 0) begin
        pop_word(16'h8000 | 16'(k), 1'b0, "t5 hdr", 200);
        for (int j = 0; j < k; j++) pop_word({2'b00, ids[j]}, (j == k - 1), "t5 body", 200);
      end
    end
    check("t5 drop_cnt", 32'(drop_cnt), 32'd2);
    check("t5 busy",     32'(busy),     32'd0);

    // 6: reset in the middle of a report
    tx_if.out_ready = 1'b0;
    send(14'h0011, 1'b0);
    send(14'h0022, 1'b0);
    send(14'h0033, 1'b1);
    ready_pct = 100;
    pop_word(16'h8003, 1'b0, "t6 hdr", 2);
    tx_if.out_ready = 1'b0;
    check("t6 body offered", 32'(tx_if.out_data), 32'h0011);
    #1 reset = 1'b1;
    #1;
    check("t6 rst valid",    32'(tx_if.out_valid), 32'd0);
    check("t6 rst last",     32'(tx_if.out_last),  32'd0);
    check("t6 rst drop_cnt", 32'(drop_cnt),        32'd0);
    check("t6 rst busy",     32'(busy),            32'd0);
    @(negedge clk);
    reset = 1'b0;
    stalled = 1'b0;
    @(negedge clk);
    check("t6 flushed valid", 32'(tx_if.out_valid), 32'd0);
    send(14'h0001, 1'b1);
    pop_word(16'h8001, 1'b0, "t6 hdr2", 2);
    pop_word(16'h0001, 1'b1, "t6 id",   0);
    check("t6 end busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
